// File: rtl/dram_pkg.sv
// Shared constants and helpers for the multi-port DRAM model.
// Holds default geometry, parameter limits and the channel-index width rule.
package dram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int MAX_NUM_CH     = 8;
  localparam int MAX_RD_LAT     = 8;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dram_mp_rr_arb.sv
// Round-robin arbiter: searches upward from ptr with wrap, first requester wins.
// ptr moves just past the winner on advance and holds otherwise.
module rr_arb
  import dram_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt
);

  logic [CH_W-1:0] ptr_r;
  logic [CH_W-1:0] gnt_idx_s;
  logic [CH_W-1:0] idx_s;
  logic            hit_s;
  logic            found_s;

  // Rotating priority search; with one channel this collapses to gnt = req.
  always_comb begin
    gnt       = {NUM_CH{1'b0}};
    gnt_idx_s = {CH_W{1'b0}};
    idx_s     = {CH_W{1'b0}};
    hit_s     = 1'b0;
    found_s   = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx_s      = CH_W'((int'(ptr_r) + off) % NUM_CH);
      hit_s      = req[idx_s] & ~found_s;
      gnt[idx_s] = gnt[idx_s] | hit_s;
      gnt_idx_s  = hit_s ? idx_s : gnt_idx_s;
      found_s    = found_s | hit_s;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_r <= {CH_W{1'b0}};
    end else if (advance && found_s) begin
      ptr_r <= (gnt_idx_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : gnt_idx_s + CH_W'(1);
    end
  end

endmodule

// File: rtl/dram_mp.sv
// Single-write, multi-requester-read memory with round-robin read arbitration
// and a fixed grant-to-data latency pipeline.
module dram_mp
  import dram_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int  NUM_CH     = 4,
  parameter int  RD_LAT     = 2,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_CH-1:0]            rd_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH-1:0]            rd_gnt,
  output logic                         rd_valid,
  output logic [CH_W-1:0]              rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

  logic [NUM_CH-1:0]     req_s;
  logic [NUM_CH-1:0]     gnt_s;
  logic                  any_gnt_s;
  logic [CH_W-1:0]       gnt_idx_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;

  logic                  vld_r  [RD_LAT];
  logic [CH_W-1:0]       ch_r   [RD_LAT];
  logic [DATA_WIDTH-1:0] data_r [RD_LAT];

  // Reset masks all requests so no grant can issue while srst is high.
  assign req_s     = srst ? {NUM_CH{1'b0}} : rd_req;
  assign any_gnt_s = |gnt_s;
  assign rd_gnt    = gnt_s;

  rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .srst    (srst),
    .req     (req_s),
    .advance (any_gnt_s),
    .gnt     (gnt_s)
  );

  // Address mux and grant encoding driven by the one-hot grant.
  always_comb begin
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    gnt_idx_s  = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_addr_s = sel_addr_s | (gnt_s[i] ? rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}});
      gnt_idx_s  = gnt_idx_s  | (gnt_s[i] ? CH_W'(i) : {CH_W{1'b0}});
    end
  end

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !srst) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Latency pipeline; data/channel stages only load behind a valid, so outputs hold.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_r[i]  <= 1'b0;
        ch_r[i]   <= {CH_W{1'b0}};
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld_r[0] <= any_gnt_s;
      if (any_gnt_s) begin
        ch_r[0]   <= gnt_idx_s;
        data_r[0] <= mem_r[sel_addr_s];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          ch_r[i]   <= ch_r[i-1];
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign rd_valid = vld_r[RD_LAT-1];
  assign rd_ch    = ch_r[RD_LAT-1];
  assign rd_data  = data_r[RD_LAT-1];

endmodule

// File: tb/tb_dram_mp.sv
// Scoreboard bench for dram_mp: a 4-channel/latency-2 instance and a
// 1-channel/latency-1 instance, each with its own reference model.
module tb_dram_mp;

  localparam int DW  = 32;
  localparam int AW4 = 18;
  localparam int AW1 = 4;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              wr_en4;
  logic [AW4-1:0]    wr_addr4;
  logic [DW-1:0]     wr_data4;
  logic [3:0]        rd_req4;
  logic [4*AW4-1:0]  rd_addr4;
  logic [3:0]        rd_gnt4;
  logic              rd_valid4;
  logic [1:0]        rd_ch4;
  logic [DW-1:0]     rd_data4;

  logic              wr_en1;
  logic [AW1-1:0]    wr_addr1;
  logic [DW-1:0]     wr_data1;
  logic [0:0]        rd_req1;
  logic [AW1-1:0]    rd_addr1;
  logic [0:0]        rd_gnt1;
  logic              rd_valid1;
  logic [0:0]        rd_ch1;
  logic [DW-1:0]     rd_data1;

  dram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW4), .NUM_CH(4), .RD_LAT(2)) dut4 (
    .clk(clk), .srst(srst), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .rd_req(rd_req4), .rd_addr(rd_addr4), .rd_gnt(rd_gnt4), .rd_valid(rd_valid4),
    .rd_ch(rd_ch4), .rd_data(rd_data4));

  dram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW1), .NUM_CH(1), .RD_LAT(1)) dut1 (
    .clk(clk), .srst(srst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_gnt(rd_gnt1), .rd_valid(rd_valid1),
    .rd_ch(rd_ch1), .rd_data(rd_data1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q4[$];
  exp_t          q1[$];
  logic [DW-1:0] mem4 [int];
  logic [DW-1:0] mem1 [int];
  int            ptr4;
  int            last_ch4;
  logic [DW-1:0] last_d4;
  logic [DW-1:0] last_d1;
  bit            mon_en = 1'b0;

  // Scoreboard for the 4-channel instance: check output side, then model the request side.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (mon_en) begin
      if (rd_valid4 === 1'b1) begin
        if (q4.size() == 0) begin
          check_eq("rd4_spurious", rd_valid4, 64'd0);
        end else begin
          e = q4.pop_front();
          check_eq("rd4_lat", cyc, e.cyc);
          check_eq("rd4_ch", rd_ch4, e.ch);
          check_eq("rd4_data", rd_data4, e.data);
          last_d4  = e.data;
          last_ch4 = e.ch;
        end
      end else begin
        check_eq("rd4_valid", rd_valid4, 64'd0);
        check_eq("rd4_hold_ch", rd_ch4, last_ch4);
        check_eq("rd4_hold_data", rd_data4, last_d4);
      end
      k = -1;
      if (!srst) begin
        for (int o = 0; o < 4; o++) begin
          if (k < 0 && rd_req4[(ptr4 + o) % 4]) k = (ptr4 + o) % 4;
        end
      end
      check_eq("gnt4", rd_gnt4, (k < 0) ? 64'd0 : (64'd1 << k));
      if (k >= 0) begin
        e.ch   = k;
        e.data = mem4[int'(rd_addr4[k*AW4 +: AW4])];
        e.cyc  = cyc + 2;
        q4.push_back(e);
        ptr4 = (k + 1) % 4;
      end
      if (srst) begin
        q4.delete();
        ptr4     = 0;
        last_d4  = '0;
        last_ch4 = 0;
      end else if (wr_en4) begin
        mem4[int'(wr_addr4)] = wr_data4;
      end
    end
  end

  // Scoreboard for the single-channel instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_eq("rd1_ch_zero", rd_ch1, 64'd0);
      if (rd_valid1 === 1'b1) begin
        if (q1.size() == 0) begin
          check_eq("rd1_spurious", rd_valid1, 64'd0);
        end else begin
          e = q1.pop_front();
          check_eq("rd1_lat", cyc, e.cyc);
          check_eq("rd1_data", rd_data1, e.data);
          last_d1 = e.data;
        end
      end else begin
        check_eq("rd1_valid", rd_valid1, 64'd0);
        check_eq("rd1_hold_data", rd_data1, last_d1);
      end
      check_eq("gnt1", rd_gnt1, srst ? 64'd0 : {63'd0, rd_req1});
      if (!srst && rd_req1[0]) begin
        e.ch   = 0;
        e.data = mem1[int'(rd_addr1)];
        e.cyc  = cyc + 1;
        q1.push_back(e);
      end
      if (srst) begin
        q1.delete();
        last_d1 = '0;
      end else if (wr_en1) begin
        mem1[int'(wr_addr1)] = wr_data1;
      end
    end
  end

  logic [3:0]    t4_exp [3] = '{4'b1000, 4'b0010, 4'b1000};
  logic [AW1-1:0] a1;
  logic [DW-1:0]  d1;

  initial begin
    srst = 1'b1;
    wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; rd_req4 = 4'b0000; rd_addr4 = {4{18'd5}};
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; rd_req1 = 1'b0; rd_addr1 = '0;
    ptr4 = 0; last_ch4 = 0; last_d4 = '0; last_d1 = '0;
    tick();
    mon_en = 1'b1;
    check_eq("rst_valid", rd_valid4, 64'd0);
    check_eq("rst_ch", rd_ch4, 64'd0);
    check_eq("rst_data", rd_data4, 64'd0);
    tick();
    srst = 1'b0;

    // Basic read of channel 2, two cycles after grant.
    wr_en4 = 1'b1; wr_addr4 = 18'd5; wr_data4 = 32'hDEADBEEF;
    tick();
    wr_en4 = 1'b0;
    rd_req4 = 4'b0100; rd_addr4[2*AW4 +: AW4] = 18'd5;
    #1;
    check_eq("t1_gnt", rd_gnt4, 64'h4);
    tick();
    rd_req4 = 4'b0000;
    check_eq("t1_early", rd_valid4, 64'd0);
    tick();
    check_eq("t1_valid", rd_valid4, 64'd1);
    check_eq("t1_ch", rd_ch4, 64'd2);
    check_eq("t1_data", rd_data4, 64'hDEADBEEF);

    // Read-before-write on a same-cycle collision.
    wr_en4 = 1'b1; wr_addr4 = 18'd9; wr_data4 = 32'h1;
    tick();
    wr_data4 = 32'h2; rd_req4 = 4'b0001; rd_addr4[0 +: AW4] = 18'd9;
    tick();
    wr_en4 = 1'b0;
    tick();
    check_eq("t2_old", rd_data4, 64'h1);
    rd_req4 = 4'b0000;
    tick();
    check_eq("t2_new", rd_data4, 64'h2);
    tick();

    // All channels requesting continuously from reset.
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_eq("t3_rst_valid", rd_valid4, 64'd0);
    check_eq("t3_rst_data", rd_data4, 64'd0);
    rd_addr4 = {18'd9, 18'd5, 18'd9, 18'd5};
    rd_req4 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t3_gnt", rd_gnt4, 64'd1 << (i % 4));
      if (i >= 2) check_eq("t3_valid", rd_valid4, 64'd1);
      tick();
    end
    rd_req4 = 4'b0000;
    tick(); tick();

    // Sparse requesters with ptr parked at 2.
    rd_req4 = 4'b0010;
    tick();
    rd_req4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_gnt", rd_gnt4, t4_exp[i]);
      tick();
    end
    rd_req4 = 4'b0000;
    tick(); tick();

    // Reset with reads in flight; write during reset must be dropped.
    rd_addr4[1*AW4 +: AW4] = 18'd5;
    rd_req4 = 4'b0011;
    tick();
    tick();
    rd_req4 = 4'b0000;
    srst = 1'b1; wr_en4 = 1'b1; wr_addr4 = 18'd5; wr_data4 = 32'h12345678;
    tick();
    srst = 1'b0; wr_en4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_no_valid", rd_valid4, 64'd0);
      tick();
    end
    rd_req4 = 4'b1010;
    #1;
    check_eq("t5_ptr0", rd_gnt4, 64'h2);
    tick();
    rd_req4 = 4'b0000;
    tick();
    check_eq("t5_mem_kept", rd_data4, 64'hDEADBEEF);
    tick();

    // Single-channel instance: random write/read pairs.
    for (int i = 0; i < 100; i++) begin
      a1 = AW1'($urandom_range(0, 15));
      d1 = $urandom;
      wr_en1 = 1'b1; wr_addr1 = a1; wr_data1 = d1;
      tick();
      wr_en1 = 1'b0; rd_req1 = 1'b1; rd_addr1 = a1;
      tick();
      rd_req1 = 1'b0;
      check_eq("t6_valid", rd_valid1, 64'd1);
      check_eq("t6_data", rd_data1, d1);
    end

    tick(); tick(); tick(); tick();
    check_eq("q4_drained", q4.size(), 64'd0);
    check_eq("q1_drained", q1.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
